nios2_system_dpram_av: RTL and testbench

NIOS2_SYSTEM_DPRAM_AV -- requirements
Module: nios2_system_dpram_av

---
 rtl/nios2_system_dpram_pkg.sv | 21 ++
 rtl/nios2_system_dpram_core.sv | 49 ++++
 rtl/nios2_system_dpram_av.sv | 131 +++++++++++++
 tb/tb_nios2_system_dpram_av.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nios2_system_dpram_pkg.sv
// Shared types and helpers for the dual-port RAM with clear engine.
package nios2_system_dpram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned MAX_DATA_W = 1024;

  // Replicates one fill byte across the widest supported word; callers slice.
  function automatic logic [MAX_DATA_W-1:0] fill_word(input logic [7:0] fill_byte);
    logic [MAX_DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      w[8*i +: 8] = fill_byte;
    end
    return w;
  endfunction

endpackage

// File: rtl/nios2_system_dpram_core.sv
// True-dual-port, byte-enabled RAM; read-before-write on both ports.
module nios2_system_dpram_core
  import nios2_system_dpram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 13
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic                a_re,
  input  logic [DATA_W/8-1:0] a_we,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic                b_re,
  input  logic [DATA_W/8-1:0] b_we,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Same-address byte overlap between ports is resolved before this point.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      if (b_we[i]) mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re) a_rdata_q <= mem_q[a_addr];
      if (b_re) b_rdata_q <= mem_q[b_addr];
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/nios2_system_dpram_av.sv
// Two Avalon-MM slave ports onto a shared dual-port RAM, plus a fill/clear engine.
//   state    | meaning
//   ST_IDLE  | ports serve transfers normally
//   ST_CLEAR | engine writes the fill word to cnt each cycle; ports stalled
module nios2_system_dpram_av
  import nios2_system_dpram_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 13,
  parameter logic [7:0]  FILL_VALUE     = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                a_chipselect,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  output logic                a_waitrequest,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_chipselect,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic                b_waitrequest,
  input  logic                clear_req,
  output logic                clear_busy
);

  localparam logic [MAX_DATA_W-1:0] FILL_FULL = fill_word(FILL_VALUE);
  localparam logic [DATA_W-1:0]     FILL_WORD = FILL_FULL[DATA_W-1:0];
  localparam logic [ADDR_W-1:0]     LAST_ADDR = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_q, init_d;
  logic              a_rdv_q, b_rdv_q;

  logic                clearing;
  logic                a_rd_acc, a_wr_acc, b_rd_acc, b_wr_acc;
  logic [DATA_W/8-1:0] b_be_eff;
  logic [ADDR_W-1:0]   core_a_addr;
  logic [DATA_W/8-1:0] core_a_we, core_b_we;
  logic [DATA_W-1:0]   core_a_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      init_q  <= CLEAR_ON_RESET;
      a_rdv_q <= 1'b0;
      b_rdv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      a_rdv_q <= a_rd_acc;
      b_rdv_q <= b_rd_acc;
    end
  end

  // clear_req is only looked at in IDLE, so a pulse during CLEAR is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req || init_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          init_d  = 1'b0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clearing      = (state_q == ST_CLEAR);
  assign clear_busy    = clearing;
  assign a_waitrequest = clearing;
  assign b_waitrequest = clearing;

  // Write takes precedence over read when both are asserted on one port.
  assign a_wr_acc = a_chipselect && a_write && !clearing;
  assign a_rd_acc = a_chipselect && a_read && !a_write && !clearing;
  assign b_wr_acc = b_chipselect && b_write && !clearing;
  assign b_rd_acc = b_chipselect && b_read && !b_write && !clearing;

  // Port A owns any byte it writes when both ports hit the same word.
  assign b_be_eff = (a_wr_acc && (a_address == b_address))
                    ? (b_byteenable & ~a_byteenable) : b_byteenable;

  assign core_a_addr  = clearing ? cnt_q : a_address;
  assign core_a_we    = clearing ? '1 : (a_wr_acc ? a_byteenable : '0);
  assign core_a_wdata = clearing ? FILL_WORD : a_writedata;
  assign core_b_we    = b_wr_acc ? b_be_eff : '0;

  nios2_system_dpram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .a_addr  (core_a_addr),
    .a_re    (a_rd_acc),
    .a_we    (core_a_we),
    .a_wdata (core_a_wdata),
    .a_rdata (a_readdata),
    .b_addr  (b_address),
    .b_re    (b_rd_acc),
    .b_we    (core_b_we),
    .b_wdata (b_writedata),
    .b_rdata (b_readdata)
  );

  assign a_readdatavalid = a_rdv_q;
  assign b_readdatavalid = b_rdv_q;

endmodule

// File: tb/tb_nios2_system_dpram_av.sv
// Directed bench for nios2_system_dpram_av at DATA_W=16, ADDR_W=4.
module tb_nios2_system_dpram_av;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  a_address, b_address;
  logic        a_chipselect, a_read, a_write, b_chipselect, b_read, b_write;
  logic [1:0]  a_byteenable, b_byteenable;
  logic [15:0] a_writedata, b_writedata;
  logic [15:0] a_readdata, b_readdata;
  logic        a_readdatavalid, b_readdatavalid, a_waitrequest, b_waitrequest;
  logic        clear_req, clear_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nios2_system_dpram_av #(
    .DATA_W (16), .ADDR_W (4), .FILL_VALUE (8'h20), .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .a_address (a_address), .a_chipselect (a_chipselect), .a_read (a_read),
    .a_write (a_write), .a_byteenable (a_byteenable), .a_writedata (a_writedata),
    .a_readdata (a_readdata), .a_readdatavalid (a_readdatavalid),
    .a_waitrequest (a_waitrequest),
    .b_address (b_address), .b_chipselect (b_chipselect), .b_read (b_read),
    .b_write (b_write), .b_byteenable (b_byteenable), .b_writedata (b_writedata),
    .b_readdata (b_readdata), .b_readdatavalid (b_readdatavalid),
    .b_waitrequest (b_waitrequest),
    .clear_req (clear_req), .clear_busy (clear_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    a_chipselect = 0; a_read = 0; a_write = 0; a_address = '0; a_byteenable = '0; a_writedata = '0;
    b_chipselect = 0; b_read = 0; b_write = 0; b_address = '0; b_byteenable = '0; b_writedata = '0;
  endtask

  // Read on port 0 (A) or 1 (B); also checks the valid pulse width and data hold.
  task automatic rd(input bit port, input logic [3:0] addr, input logic [15:0] exp, input string tag);
    if (port == 0) begin a_chipselect = 1; a_read = 1; a_address = addr; end
    else           begin b_chipselect = 1; b_read = 1; b_address = addr; end
    @(posedge clk); #1;
    idle_inputs();
    chk({tag, "_rdv"}, port ? b_readdatavalid : a_readdatavalid, 1);
    chk(tag, port ? b_readdata : a_readdata, {16'h0, exp});
    @(posedge clk); #1;
    chk({tag, "_rdv_off"}, port ? b_readdatavalid : a_readdatavalid, 0);
    chk({tag, "_hold"}, port ? b_readdata : a_readdata, {16'h0, exp});
  endtask

  task automatic wr_a(input logic [3:0] addr, input logic [15:0] d, input logic [1:0] be);
    a_chipselect = 1; a_write = 1; a_address = addr; a_writedata = d; a_byteenable = be;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Counts busy cycles; optionally pulses clear_req at sample pulse_at and
  // holds an A write / B read across the clear.
  task automatic count_clear(input int pulse_at, input bit hold_xfer, output int n,
                             output int wr_bad, output int rdv_busy);
    n = 0; wr_bad = 0; rdv_busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      clear_req = (k == pulse_at);
      if (a_waitrequest !== clear_busy || b_waitrequest !== clear_busy) wr_bad++;
      if (clear_busy === 1'b1) begin
        n++;
        if (a_readdatavalid || b_readdatavalid) rdv_busy++;
        if (hold_xfer && k == 0) begin
          a_chipselect = 1; a_write = 1; a_address = 4'd9; a_writedata = 16'h1234; a_byteenable = 2'b11;
          b_chipselect = 1; b_read = 1; b_address = 4'd3;
        end
      end else if (n > 0) begin
        break;
      end
    end
    clear_req = 0;
  endtask

  int n_busy, n_wr_bad, n_rdv_busy;

  initial begin
    reset_n = 1'b1;
    clear_req = 0;
    idle_inputs();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_busy", clear_busy, 0);
    chk("rst_wait_a", a_waitrequest, 0);
    chk("rst_wait_b", b_waitrequest, 0);
    chk("rst_rdv_a", a_readdatavalid, 0);
    chk("rst_rdata_a", a_readdata, 0);
    chk("rst_rdata_b", b_readdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Automatic clear after reset release.
    count_clear(-1, 0, n_busy, n_wr_bad, n_rdv_busy);
    chk("auto_clear_len", n_busy, 16);
    chk("auto_clear_wait", n_wr_bad, 0);
    for (int i = 0; i < 16; i++) rd(0, 4'(i), 16'h2020, $sformatf("fill_rd%0d", i));

    // Byte-enabled write on A.
    wr_a(4'd3, 16'hBEEF, 2'b01);
    chk("no_rdv_on_write", a_readdatavalid, 0);
    rd(0, 4'd3, 16'h20EF, "be_write");

    // Read+write together on one port: write done, no read.
    a_chipselect = 1; a_read = 1; a_write = 1; a_address = 4'd4; a_writedata = 16'h4444; a_byteenable = 2'b11;
    @(posedge clk); #1;
    idle_inputs();
    chk("rw_both_no_rdv", a_readdatavalid, 0);
    rd(1, 4'd4, 16'h4444, "rw_both_data");

    // Same-address writes from both ports.
    a_chipselect = 1; a_write = 1; a_address = 4'd5; a_writedata = 16'h1111; a_byteenable = 2'b01;
    b_chipselect = 1; b_write = 1; b_address = 4'd5; b_writedata = 16'h2222; b_byteenable = 2'b11;
    @(posedge clk); #1;
    idle_inputs();
    rd(0, 4'd5, 16'h2211, "ww_collision");

    // A write with concurrent B read of same address: old data first.
    a_chipselect = 1; a_write = 1; a_address = 4'd7; a_writedata = 16'h0A0A; a_byteenable = 2'b11;
    b_chipselect = 1; b_read = 1; b_address = 4'd7;
    @(posedge clk); #1;
    idle_inputs();
    chk("rw_collision_rdv", b_readdatavalid, 1);
    chk("rw_collision_old", b_readdata, 16'h2020);
    @(posedge clk); #1;
    rd(1, 4'd7, 16'h0A0A, "rw_collision_new");

    // Requested clear with a second, ignored pulse and stalled transfers.
    clear_req = 1;
    count_clear(4, 1, n_busy, n_wr_bad, n_rdv_busy);
    chk("req_clear_len", n_busy, 16);
    chk("req_clear_wait", n_wr_bad, 0);
    chk("req_clear_stalled", n_rdv_busy, 0);
    @(posedge clk); #1;
    idle_inputs();
    chk("post_clear_b_rdv", b_readdatavalid, 1);
    chk("post_clear_b_data", b_readdata, 16'h2020);
    chk("no_restart", clear_busy, 0);
    rd(0, 4'd9, 16'h1234, "stalled_write");
    rd(0, 4'd7, 16'h2020, "cleared_addr7");

    // Read accepted the cycle clear starts, then reset mid-clear.
    clear_req = 1; a_chipselect = 1; a_read = 1; a_address = 4'd9;
    @(posedge clk); #1;
    clear_req = 0;
    idle_inputs();
    chk("pre_clear_busy", clear_busy, 1);
    chk("pre_clear_rdv", a_readdatavalid, 1);
    chk("pre_clear_rdata", a_readdata, 16'h1234);
    n_busy = 1;
    for (int k = 0; k < 20 && n_busy < 8; k++) begin
      @(posedge clk); #1;
      if (clear_busy) n_busy++;
    end
    chk("mid_clear_cycles", n_busy, 8);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", clear_busy, 0);
    chk("abort_wait_a", a_waitrequest, 0);
    chk("abort_wait_b", b_waitrequest, 0);
    chk("abort_rdv_a", a_readdatavalid, 0);
    chk("abort_rdata_a", a_readdata, 0);
    chk("abort_rdata_b", b_readdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    count_clear(-1, 0, n_busy, n_wr_bad, n_rdv_busy);
    chk("reclear_len", n_busy, 16);
    chk("reclear_wait", n_wr_bad, 0);
    rd(1, 4'd9, 16'h2020, "reclear_addr9");
    rd(0, 4'd0, 16'h2020, "reclear_addr0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
